// File: rtl/cordic_post_scale_if.sv
// cordic_post_scale_if: valid/ready bundle between the last CORDIC stage, the post-scale block and its consumer.
interface cordic_post_scale_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x_in;
   logic [W-1:0] y_in;
   logic [W-1:0] z_in;
   logic [1:0]   quad_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] cos_out;
   logic [W-1:0] sin_out;
   logic [W-1:0] z_res_out;
   modport master (
      output in_valid, x_in, y_in, z_in, quad_in, out_ready,
      input  in_ready, out_valid, cos_out, sin_out, z_res_out
   );
   modport slave (
      input  in_valid, x_in, y_in, z_in, quad_in, out_ready,
      output in_ready, out_valid, cos_out, sin_out, z_res_out
   );
endinterface

// File: rtl/cordic_post_scale.sv
// cordic_post_scale: CORDIC gain compensation and quadrant fix-up, two-stage valid/ready pipeline.
// Define CORDIC_POST_ROUND_EN to round the gain product to nearest instead of truncating.
module cordic_post_scale #(
   parameter int          W      = 32,
   parameter logic [31:0] K_GAIN = 32'h9B74EDA8
) (
   input logic            clk,
   input logic            rst_n,
   cordic_post_scale_if.slave s
);
`ifdef CORDIC_POST_ROUND_EN
   localparam logic signed [2*W:0] RND = (2*W+1)'(1) <<< 31;
`else
   localparam logic signed [2*W:0] RND = '0;
`endif
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
   logic                  en;
   logic signed [2*W:0]   xe, ye, ke, px, py;
   logic                  unused_bits;
   logic                  v1, v2;
   logic [W-1:0]          xs, ys, z1, nxs, nys;
   logic [1:0]            q1;
   logic [W-1:0]          cos_n, sin_n, cos_r, sin_r, z_r;
   assign en         = !v2 || s.out_ready;
   assign s.in_ready = en;
   assign s.out_valid = v2;
   assign s.cos_out   = cos_r;
   assign s.sin_out   = sin_r;
   assign s.z_res_out = z_r;
   // K is unsigned, so it is zero-extended before the signed multiply
   assign xe = {{(W+1){s.x_in[W-1]}}, s.x_in};
   assign ye = {{(W+1){s.y_in[W-1]}}, s.y_in};
   assign ke = {{(W+1){1'b0}}, K_GAIN};
   assign px = xe * ke + RND;
   assign py = ye * ke + RND;
   assign unused_bits = ^{px[2*W], px[W-1:0], py[2*W], py[W-1:0]};
   assign nxs = (xs == MIN_NEG) ? ~MIN_NEG : -xs;
   assign nys = (ys == MIN_NEG) ? ~MIN_NEG : -ys;
   always_comb begin
      cos_n = (q1 == 2'd0) ? xs : (q1 == 2'd1) ? nys : (q1 == 2'd2) ? ys  : nxs;
      sin_n = (q1 == 2'd0) ? ys : (q1 == 2'd1) ? xs  : (q1 == 2'd2) ? nxs : nys;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         xs <= '0;
         ys <= '0;
         z1 <= '0;
         q1 <= '0;
      end else if (en) begin
         v1 <= s.in_valid;
         if (s.in_valid) begin
            xs <= px[2*W-1:W];
            ys <= py[2*W-1:W];
            z1 <= s.z_in;
            q1 <= s.quad_in;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         cos_r <= '0;
         sin_r <= '0;
         z_r   <= '0;
      end else if (en) begin
         v2 <= v1;
         if (v1) begin
            cos_r <= cos_n;
            sin_r <= sin_n;
            z_r   <= z1;
         end
      end
   end
endmodule

// File: doc/cordic_post_scale.md
Name: cordic_post_scale

Overview:
- Final stage of the pipelined rotation-mode CORDIC. It sits directly downstream of the last shift/accumulate stage.
- Takes the un-normalised x/y/z results and multiplies x and y by the CORDIC gain compensation constant K ≈ 0.6072529350.
- Undoes the quadrant pre-rotation using a 2-bit quadrant tag carried alongside the data.
- Presents cos/sin results with a valid/ready handshake to the consumer.

Parameters:
- W, 32: data width of x, y and z. Only 32 is required to be supported.
- K_GAIN, 32'h9B74EDA8: unsigned Q0.32 gain compensation constant (0.6072529350).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x_in/y_in/z_in/quad_in are valid this cycle.
- in_ready  output  1  stage accepts input this cycle.
- x_in  input  32  signed Q2.30 x from the last CORDIC stage.
- y_in  input  32  signed Q2.30 y from the last CORDIC stage.
- z_in  input  32  residual angle, signed, same format as the stage z.
- quad_in  input  2  pre-rotation tag: 0 none, 1 θ=φ+π/2, 2 θ=φ−π/2, 3 θ=φ+π.
- out_valid  output  1  outputs hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- cos_out  output  32  signed Q2.30 cos θ.
- sin_out  output  32  signed Q2.30 sin θ.
- z_res_out  output  32  residual angle, delayed and unmodified.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, stage-1 valid=0, cos_out=0, sin_out=0, z_res_out=0, and all internal data registers =0. Release is synchronous to clk.
- Two-stage pipeline. Latency from accepted input to out_valid is 2 cycles when there is no stall.
- Stage 1:
  - xs = (signed x_in × unsigned K_GAIN) >>> 32.
  - ys is computed the same way from y_in.
  - The product is 65-bit signed. Keep bits [63:32], arithmetic.
  - quad_in and z_in are registered alongside xs/ys.
- Stage 2 (quadrant fix-up):
  - quad 0: cos=xs, sin=ys.
  - quad 1: cos=−ys, sin=xs.
  - quad 2: cos=ys, sin=−xs.
  - quad 3: cos=−xs, sin=−ys.
  - Negation saturates: −0x80000000 gives 0x7FFFFFFF. No other saturation is applied.
- Handshake:
  - Pipeline enable en = !out_valid || out_ready.
  - in_ready = en.
  - A transfer occurs on the in side when in_valid && in_ready, and on the out side when out_valid && out_ready.
  - Stall (out_valid && !out_ready): both stages hold their contents. cos_out, sin_out and z_res_out stay stable.
  - Bubbles propagate. Stage-1 valid follows in_valid when en=1; out_valid follows stage-1 valid when en=1.
  - Full throughput: one result per cycle with out_ready held high.
- Simultaneous input accept and output drain in the same cycle: both transfers happen and nothing is lost.
- Reset asserted mid-stream: all in-flight data is discarded and out_valid drops immediately.

Optional Feature:
- Macro: CORDIC_POST_ROUND_EN.
- Defined: the stage-1 product is rounded to nearest by adding 2^31 before taking [63:32] (ties round up).
- Undefined: the product is truncated toward −∞ (arithmetic shift only).
- Handshake and latency are identical in both builds.

Test Plan:
1. Reset, then x_in=0x40000000, y_in=0, z_in=0x00000123, quad 0, out_ready=1 -> after 2 cycles out_valid=1, cos_out=0x26DD3B6A, sin_out=0, z_res_out=0x00000123.
2. Same data with quad 3 -> cos_out=0xD922C496, sin_out=0. With quad 1 and x_in=0, y_in=0x40000000 -> cos_out=0xD922C496, sin_out=0.
3. x_in=0x00000001, quad 0 -> cos_out=0 when CORDIC_POST_ROUND_EN is undefined, 1 when it is defined.
4. Stream 4 back-to-back inputs and hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 during the stall, outputs stable, then all 4 results emerge in order with no loss or duplicates.
5. Input ys = 0x80000000 (after scaling) forced via a quad 1 corner case, or directly check negation of 0x80000000 -> saturates to 0x7FFFFFFF.
6. Assert rst_n low while 2 results are in flight -> out_valid=0 and outputs=0 immediately (asynchronous). After release, the first new input appears 2 cycles later.
